// File: rtl/mips_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// Executes MULT/MULTU/DIV/DIVU over WIDTH cycles; MTHI/MTLO write directly.
module mips_muldiv_unit #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mag, acc_hi, acc_lo;
  logic             is_div, neg_q, neg_r, div_zero;

  // Issue decode: ops 0-3 are arithmetic, bit0 selects unsigned, bit1 selects divide.
  logic             accept, go_arith, op_signed, op_div, a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;

  assign accept    = (state == IDLE) && start && !cancel;
  assign go_arith  = accept && !op[2];
  assign op_signed = !op[0];
  assign op_div    = op[1];
  assign a_neg     = op_signed && src_a[WIDTH-1];
  assign b_neg     = op_signed && src_b[WIDTH-1];
  assign abs_a     = a_neg ? -src_a : src_a;
  assign abs_b     = b_neg ? -src_b : src_b;

  // One iteration: shift-add multiply or restoring divide on magnitudes.
  logic [WIDTH:0]   mul_sum, div_trial;
  logic [WIDTH-1:0] div_diff, step_hi, step_lo;
  logic             div_ge;

  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag} : '0);
  assign div_trial = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge    = div_trial >= {1'b0, mag};
  assign div_diff  = div_trial[WIDTH-1:0] - mag;
  assign step_hi   = is_div ? (div_ge ? div_diff : div_trial[WIDTH-1:0]) : mul_sum[WIDTH:1];
  assign step_lo   = is_div ? {acc_lo[WIDTH-2:0], div_ge} : {mul_sum[0], acc_lo[WIDTH-1:1]};

  // Sign correction applied in FIX; remainder follows the dividend's sign.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign prod_fix = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  assign res_hi   = is_div ? (neg_r ? -acc_hi : acc_hi) : prod_fix[2*WIDTH-1:WIDTH];
  assign res_lo   = is_div ? (div_zero ? '1 : (neg_q ? -acc_lo : acc_lo))
                           : prod_fix[WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: assign every always_comb output a default first so no path leaves it unassigned (latch).
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (go_arith) state_next = RUN;
      RUN: begin
        if (cancel)                          state_next = IDLE;
        else if (cnt == CNT_W'(WIDTH - 1))   state_next = FIX;
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the working registers are flops, not a RAM, so clearing them on reset is cheap and required.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      mag      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      done <= 1'b0;
      busy <= (state_next != IDLE);
      unique case (state)
        IDLE: begin
          if (go_arith) begin
            cnt      <= '0;
            is_div   <= op_div;
            mag      <= op_div ? abs_b : abs_a;
            acc_hi   <= '0;
            acc_lo   <= op_div ? abs_b_or_a(abs_a, abs_b, 1'b1) : abs_b;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= op_div && a_neg;
            div_zero <= op_div && (src_b == '0);
          end else if (accept && op == OP_MTHI) begin
            hi <= src_a;
          end else if (accept && op == OP_MTLO) begin
            lo <= src_a;
          end
        end
        RUN: begin
          if (!cancel) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt + 1'b1;
          end
        end
        FIX: begin
          if (!cancel) begin
            hi   <= res_hi;
            lo   <= res_lo;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Divide loads the dividend magnitude into the shifting quotient register.
  function automatic logic [WIDTH-1:0] abs_b_or_a(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y,
                                                  input logic             pick_x);
    return pick_x ? x : y;
  endfunction

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit: vector table at WIDTH=32 plus
// hand sequences for MTHI/MTLO, cancel, busy-start, async reset and WIDTH=8.
module tb_mips_muldiv_unit;

  localparam int W  = 32;
  localparam int W8 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b0, start = 1'b0, cancel = 1'b0;
  logic [2:0]    op = '0;
  logic [W-1:0]  a = '0, b = '0;
  logic          busy, done;
  logic [W-1:0]  hi, lo;

  logic          rst8 = 1'b0, start8 = 1'b0, cancel8 = 1'b0;
  logic [2:0]    op8 = '0;
  logic [W8-1:0] a8 = '0, b8 = '0;
  logic          busy8, done8;
  logic [W8-1:0] hi8, lo8;

  mips_muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(rst), .start(start), .op(op), .src_a(a), .src_b(b),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  mips_muldiv_unit #(.WIDTH(W8)) dut8 (
    .clk(clk), .reset(rst8), .start(start8), .op(op8), .src_a(a8), .src_b(b8),
    .cancel(cancel8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t vecs[13];

  // Issue one arithmetic op and check latency, busy width and the result.
  task automatic run32(input int idx, input vec_t v);
    int e, bc;
    @(negedge clk);
    start = 1'b1; op = v.op; a = v.a; b = v.b;
    @(negedge clk);
    start = 1'b0;
    e = 0; bc = 0;
    while (!done && e < 200) begin
      if (busy) bc++;
      @(negedge clk);
      e++;
    end
    check($sformatf("v%0d latency", idx), 64'(e), 64'(W + 1));
    check($sformatf("v%0d busy_cycles", idx), 64'(bc), 64'(W + 1));
    check($sformatf("v%0d busy_at_done", idx), 64'(busy), 64'(0));
    check($sformatf("v%0d hi", idx), 64'(hi), 64'(v.hi));
    check($sformatf("v%0d lo", idx), 64'(lo), 64'(v.lo));
    @(negedge clk);
    check($sformatf("v%0d done_pulse", idx), 64'(done), 64'(0));
  endtask

  // Watch for n cycles and return whether done was ever seen.
  task automatic watch_done(input int n, output logic seen);
    seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
  endtask

  initial begin
    int   e, bc;
    logic seen;
    logic seen_busy;

    vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1]  = '{3'd3, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[2]  = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{3'd2, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF};
    vecs[4]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[6]  = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[7]  = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[8]  = '{3'd3, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[9]  = '{3'd2, 32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFF8, 32'hFFFF_FFFF};
    vecs[10] = '{3'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
    vecs[11] = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[12] = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000};

    #1 rst = 1'b1; rst8 = 1'b1;
    #1;
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    check("reset hi", 64'(hi), 64'(0));
    check("reset lo", 64'(lo), 64'(0));
    check("reset8 hi/lo/busy", 64'({busy8, done8, hi8, lo8}), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; rst8 = 1'b0;

    for (int i = 0; i < 13; i++) run32(i, vecs[i]);

    // MTHI then MTLO on consecutive cycles: no busy, no done.
    seen_busy = 1'b0; seen = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'hAAAA_0000;
    @(negedge clk);
    if (busy || done) begin seen_busy |= busy; seen |= done; end
    op = 3'd5; a = 32'h0000_5555;
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      seen_busy |= busy; seen |= done;
      @(negedge clk);
    end
    check("mt busy", 64'(seen_busy), 64'(0));
    check("mt done", 64'(seen), 64'(0));
    check("mt hi", 64'(hi), 64'(32'hAAAA_0000));
    check("mt lo", 64'(lo), 64'(32'h0000_5555));

    // Reserved op has no effect.
    start = 1'b1; op = 3'd6; a = 32'hDEAD_BEEF; b = 32'h1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("rsvd busy", 64'(busy), 64'(0));
    check("rsvd hi/lo", 64'({hi, lo}), 64'({32'hAAAA_0000, 32'h0000_5555}));

    // cancel together with start in IDLE suppresses the start.
    start = 1'b1; cancel = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3;
    @(negedge clk);
    check("idle cancel busy", 64'(busy), 64'(0));
    op = 3'd4; a = 32'h1234_0000;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check("idle cancel mthi", 64'(hi), 64'(32'hAAAA_0000));

    // Cancel MULTU during RUN at cycle 10.
    start = 1'b1; op = 3'd1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("run cancel pre busy", 64'(busy), 64'(1));
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("run cancel busy", 64'(busy), 64'(0));
    watch_done(W + 4, seen);
    check("run cancel done", 64'(seen), 64'(0));
    check("run cancel hi/lo", 64'({hi, lo}), 64'({32'hAAAA_0000, 32'h0000_5555}));

    // Cancel in the FIX cycle.
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (W) @(negedge clk);
    check("fix cancel pre busy", 64'(busy), 64'(1));
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("fix cancel done", 64'(done), 64'(0));
    check("fix cancel busy", 64'(busy), 64'(0));
    watch_done(4, seen);
    check("fix cancel late done", 64'(seen), 64'(0));
    check("fix cancel hi/lo", 64'({hi, lo}), 64'({32'hAAAA_0000, 32'h0000_5555}));

    // start while busy is ignored; the original DIVU result stands.
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    e = 0; bc = 0;
    repeat (3) begin @(negedge clk); e++; end
    start = 1'b1; op = 3'd0; a = 32'd7; b = 32'hFFFF_FFFD;
    @(negedge clk); e++;
    op = 3'd4; a = 32'h0000_0BAD;
    @(negedge clk); e++;
    start = 1'b0;
    while (!done && e < 200) begin
      @(negedge clk);
      e++;
    end
    check("busy start latency", 64'(e), 64'(W + 1));
    check("busy start hi", 64'(hi), 64'(2));
    check("busy start lo", 64'(lo), 64'(14));

    // Asynchronous reset mid-RUN clears state between clock edges.
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd7; b = 32'hFFFF_FFFD;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async rst busy", 64'(busy), 64'(0));
    check("async rst hi", 64'(hi), 64'(0));
    check("async rst lo", 64'(lo), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    watch_done(W + 4, seen);
    check("async rst done", 64'(seen), 64'(0));

    // WIDTH=8: MULT 0x80*0x80 completes at edge N+9.
    @(negedge clk);
    start8 = 1'b1; op8 = 3'd0; a8 = 8'h80; b8 = 8'h80;
    @(negedge clk);
    start8 = 1'b0;
    e = 0; bc = 0;
    while (!done8 && e < 100) begin
      if (busy8) bc++;
      @(negedge clk);
      e++;
    end
    check("w8 latency", 64'(e), 64'(W8 + 1));
    check("w8 busy_cycles", 64'(bc), 64'(W8 + 1));
    check("w8 hi", 64'(hi8), 64'(8'h40));
    check("w8 lo", 64'(lo8), 64'(8'h00));

    // WIDTH=8 DIV overflow corner.
    @(negedge clk);
    start8 = 1'b1; op8 = 3'd2; a8 = 8'h80; b8 = 8'hFF;
    @(negedge clk);
    start8 = 1'b0;
    e = 0;
    while (!done8 && e < 100) begin
      @(negedge clk);
      e++;
    end
    check("w8 div latency", 64'(e), 64'(W8 + 1));
    check("w8 div hi/lo", 64'({hi8, lo8}), 64'({8'h00, 8'h80}));

    // WIDTH=8 async reset mid-RUN.
    @(negedge clk);
    start8 = 1'b1; op8 = 3'd1; a8 = 8'hFF; b8 = 8'hFF;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst8 = 1'b1;
    #1;
    check("w8 async rst", 64'({busy8, hi8, lo8}), 64'(0));
    @(negedge clk);
    rst8 = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
Parametrised iterative multiply/divide unit with architectural HI/LO registers. It sits beside the ALU in the Execute stage of the 5-stage MIPS pipeline and accepts one operation per issue. It runs multi-cycle and reports busy to the stall logic, so that dependent MFHI/MFLO reads stall the front end instead of reading stale HI/LO.

Parameters:
WIDTH, 32, operand/HI/LO width in bits (>=4, even).
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden).

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high; clears all state.
start  input  1  issue strobe from EX stage; sampled only when busy=0.
op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6,7 reserved (ignored).
src_a  input  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data).
src_b  input  WIDTH  rt operand (multiplier / divisor).
cancel  input  1  flush of the issuing instruction; aborts an operation in progress.
busy  output  1  high while an arithmetic operation is in flight; feeds the stall unit.
done  output  1  one-cycle pulse when HI/LO are updated by an arithmetic op.
hi  output  WIDTH  HI register.
lo  output  WIDTH  LO register.

Behaviour:
- Reset (async): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, internal accumulators=0.
- FSM states: IDLE, RUN, FIX.
- IDLE:
  - start with op 0-3 -> latch |a|, |b|, and result signs (signed ops only), counter=0 -> RUN; busy=1 from the next cycle.
  - start with op 4/5 -> hi/lo <= src_a at that edge; stay IDLE; no done pulse; busy stays 0.
  - Reserved ops: no effect.
- RUN: one radix-2 step per cycle (shift-add multiply, restoring divide on magnitudes); counter increments; after WIDTH steps -> FIX.
- FIX: apply sign correction and write hi/lo; done=1 for this single cycle; -> IDLE; busy=0 from the next cycle.
- Latency: start sampled at edge N; hi/lo valid and done high after edge N+WIDTH+1; start accepted again at edge N+WIDTH+2.
- busy is registered: high in every cycle from the one after the start edge through the FIX cycle.
- Multiply: {hi,lo} = full 2*WIDTH-bit product; signed when op=0.
- Divide: lo = quotient (truncated toward zero), hi = remainder (sign follows dividend).
- Divide by zero (src_b=0): lo = all ones, hi = src_a; same latency, done still pulses.
- Signed overflow (src_a = most-negative value, src_b=-1, op=DIV): lo = most-negative value, hi = 0.
- start while busy=1: ignored, no state change; it is the caller's responsibility via stall.
- cancel:
  - While in RUN or FIX, cancel=1 at an edge -> IDLE, hi/lo keep their pre-operation values, no done.
  - cancel in IDLE has no effect.
  - cancel and start in the same cycle in IDLE -> start is ignored.
- hi/lo change only on FIX completion, MTHI/MTLO, or reset; hold their values during RUN.
- Reset asserted mid-operation -> immediate IDLE with hi=lo=0; no done.

Test Plan:
- MULT, WIDTH=32, src_a=7, src_b=0xFFFFFFFD -> done at edge N+33, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for exactly 33 cycles.
- DIVU 100/7 -> lo=14, hi=2. DIV 0xFFFFFFF9/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV by zero with src_a=0x12345678 -> lo=0xFFFFFFFF, hi=0x12345678. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0xAAAA0000, then MTLO 0x5555 on consecutive cycles -> hi=0xAAAA0000, lo=0x5555, busy never asserts, no done.
- MULTU 0xFFFFFFFF*0xFFFFFFFF with cancel at cycle 10 -> IDLE, hi/lo unchanged, no done. Second start issued while busy -> ignored, the original result stands.
- Reset pulse asserted asynchronously mid-RUN (between edges) -> busy, hi, lo go to 0 without waiting for a clock edge. Repeat at WIDTH=8 with MULT 0x80*0x80 -> hi=0x40, lo=0x00, done at edge N+9.
